coin_acceptor: RTL

Upstream front-end of the vending machine FSM. Synchronises and debounces the raw coin-mechanism sensor lines and emits clean single-cycle coin5/coin10 pulses to the FSM. Maintains a running credit total and rejects coins that are ambiguous or would overflow it. Runs a paced refund sequence that ejects the held credit as Rs.10/Rs.5 coins.

---
 rtl/coin_acceptor_if.sv | 48 ++++
 rtl/coin_acceptor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: bundles the sensor inputs, the vending-FSM controls and the
// pulse/credit outputs of the coin acceptor.
// Optional build macro: COIN_ACCEPTOR_AUDIT_EN adds accept_count/reject_count.
//
// Signalling: there is no valid/ready handshake here. Every output "event"
// (coin5, coin10, reject, refund5, refund10) is a registered single-cycle pulse
// that the consumer must take in the cycle it is high; credit is a registered
// level that changes in the same cycle as the pulse that altered it, and
// refund_busy is a registered level high for the whole refund sequence.
interface coin_acceptor_if #(
  parameter int CREDIT_W = 6
);
  logic                sense5_raw;
  logic                sense10_raw;
  logic                credit_clear;
  logic                refund_req;
  logic                coin5;
  logic                coin10;
  logic [CREDIT_W-1:0] credit;
  logic                reject;
  logic                refund5;
  logic                refund10;
  logic                refund_busy;
`ifdef COIN_ACCEPTOR_AUDIT_EN
  logic [7:0]          accept_count;
  logic [7:0]          reject_count;
`endif

  // Driver side: sensors and vending FSM.
  modport master (
    output sense5_raw, output sense10_raw, output credit_clear, output refund_req,
    input  coin5, input coin10, input credit, input reject,
    input  refund5, input refund10, input refund_busy
`ifdef COIN_ACCEPTOR_AUDIT_EN
    , input accept_count, input reject_count
`endif
  );

  // Acceptor side.
  modport slave (
    input  sense5_raw, input sense10_raw, input credit_clear, input refund_req,
    output coin5, output coin10, output credit, output reject,
    output refund5, output refund10, output refund_busy
`ifdef COIN_ACCEPTOR_AUDIT_EN
    , output accept_count, output reject_count
`endif
  );
endinterface

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and debounces the two coin sensors, turns rising
// debounced edges into coin events, keeps the running credit, rejects coins that
// are ambiguous or would overflow the credit, and runs a paced refund sequence.
// Optional build macro: COIN_ACCEPTOR_AUDIT_EN adds saturating accept/reject
// counters on the interface.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CREDIT_W        = 6,
  parameter int MAX_CREDIT      = 40,
  parameter int REFUND_GAP      = 8
) (
  input  logic             clk,
  input  logic             reset,
  coin_acceptor_if.slave   bus,
  output logic             o_dbg_state
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int GAP_W = $clog2(REFUND_GAP + 1);
  localparam int CW1   = CREDIT_W + 1;
  localparam logic [CW1-1:0] MAX_EXT = CW1'(MAX_CREDIT);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_REFUND = 1'b1
  } state_t;

  // Channel index 0 = Rs.5 sensor, 1 = Rs.10 sensor.
  logic [1:0]          w_raw;
  logic [1:0]          r_meta;
  logic [1:0]          r_sync;
  logic [DB_W-1:0]     r_cnt [2];
  logic [1:0]          r_lvl;
  logic [1:0]          r_lvl_d;
  logic                w_ev5;
  logic                w_ev10;
  logic                w_any_ev;

  state_t              r_state;
  state_t              w_state_n;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_n;
  logic [GAP_W-1:0]    r_gap;
  logic [GAP_W-1:0]    w_gap_n;
  logic                r_coin5,    w_coin5_n;
  logic                r_coin10,   w_coin10_n;
  logic                r_reject,   w_reject_n;
  logic                r_refund5,  w_refund5_n;
  logic                r_refund10, w_refund10_n;
  logic                r_busy,     w_busy_n;
  logic                w_do_refund;
  logic [CW1-1:0]      w_sum5;
  logic [CW1-1:0]      w_sum10;

  assign w_raw    = {bus.sense10_raw, bus.sense5_raw};
  // An event is a rising debounced level; falling edges are ignored.
  assign w_ev5    = r_lvl[0] & ~r_lvl_d[0];
  assign w_ev10   = r_lvl[1] & ~r_lvl_d[1];
  assign w_any_ev = w_ev5 | w_ev10;
  assign w_sum5   = {1'b0, r_credit} + CW1'(5);
  assign w_sum10  = {1'b0, r_credit} + CW1'(10);

  // Two-flop synchroniser, then a debouncer that flips the level only after
  // DEBOUNCE_CYCLES consecutive disagreeing synced samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_lvl    <= '0;
      r_lvl_d  <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_meta  <= w_raw;
      r_sync  <= r_meta;
      r_lvl_d <= r_lvl;
      for (int ch = 0; ch < 2; ch++) begin
        if (r_sync[ch] != r_lvl[ch]) begin
          if (r_cnt[ch] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_lvl[ch] <= r_sync[ch];
            r_cnt[ch] <= '0;
          end else begin
            r_cnt[ch] <= r_cnt[ch] + 1'b1;
          end
        end else begin
          r_cnt[ch] <= '0;
        end
      end
    end
  end

  // Next-state, credit and pulse decisions; one event per cycle, highest priority first.
  always_comb begin
    w_state_n    = r_state;
    w_credit_n   = r_credit;
    w_gap_n      = r_gap;
    w_coin5_n    = 1'b0;
    w_coin10_n   = 1'b0;
    w_reject_n   = 1'b0;
    w_refund5_n  = 1'b0;
    w_refund10_n = 1'b0;
    w_do_refund  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.credit_clear) begin
          w_credit_n = '0;
          w_reject_n = w_any_ev;
        end else if (bus.refund_req && (r_credit != '0)) begin
          // First refund coin leaves in the same cycle the sequence starts.
          w_state_n   = S_REFUND;
          w_reject_n  = w_any_ev;
          w_do_refund = 1'b1;
        end else if (w_ev5 && w_ev10) begin
          w_reject_n = 1'b1;
        end else if (w_ev10) begin
          if (w_sum10 > MAX_EXT) begin
            w_reject_n = 1'b1;
          end else begin
            w_coin10_n = 1'b1;
            w_credit_n = w_sum10[CREDIT_W-1:0];
          end
        end else if (w_ev5) begin
          if (w_sum5 > MAX_EXT) begin
            w_reject_n = 1'b1;
          end else begin
            w_coin5_n  = 1'b1;
            w_credit_n = w_sum5[CREDIT_W-1:0];
          end
        end
      end
      S_REFUND: begin
        // Coins arriving while refunding always go to the return chute.
        w_reject_n = w_any_ev;
        if (r_credit == '0) begin
          w_state_n = S_IDLE;
        end else if (r_gap == '0) begin
          w_do_refund = 1'b1;
        end else begin
          w_gap_n = r_gap - 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
    if (w_do_refund) begin
      w_gap_n = GAP_W'(REFUND_GAP);
      if (r_credit >= CREDIT_W'(10)) begin
        w_refund10_n = 1'b1;
        w_credit_n   = r_credit - CREDIT_W'(10);
      end else if (r_credit >= CREDIT_W'(5)) begin
        w_refund5_n = 1'b1;
        w_credit_n  = r_credit - CREDIT_W'(5);
      end
    end
    w_busy_n = (w_state_n == S_REFUND);
  end

  // State, credit and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_credit   <= '0;
      r_gap      <= '0;
      r_coin5    <= 1'b0;
      r_coin10   <= 1'b0;
      r_reject   <= 1'b0;
      r_refund5  <= 1'b0;
      r_refund10 <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_credit   <= w_credit_n;
      r_gap      <= w_gap_n;
      r_coin5    <= w_coin5_n;
      r_coin10   <= w_coin10_n;
      r_reject   <= w_reject_n;
      r_refund5  <= w_refund5_n;
      r_refund10 <= w_refund10_n;
      r_busy     <= w_busy_n;
    end
  end

  assign bus.coin5       = r_coin5;
  assign bus.coin10      = r_coin10;
  assign bus.reject      = r_reject;
  assign bus.refund5     = r_refund5;
  assign bus.refund10    = r_refund10;
  assign bus.refund_busy = r_busy;
  assign bus.credit      = r_credit;
  assign o_dbg_state     = r_state;

`ifdef COIN_ACCEPTOR_AUDIT_EN
  logic [7:0] r_accept_cnt;
  logic [7:0] r_reject_cnt;

  // Saturating audit counters, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_accept_cnt <= '0;
      r_reject_cnt <= '0;
    end else begin
      if ((w_coin5_n || w_coin10_n) && (r_accept_cnt != 8'hFF)) begin
        r_accept_cnt <= r_accept_cnt + 8'd1;
      end
      if (w_reject_n && (r_reject_cnt != 8'hFF)) begin
        r_reject_cnt <= r_reject_cnt + 8'd1;
      end
    end
  end

  assign bus.accept_count = r_accept_cnt;
  assign bus.reject_count = r_reject_cnt;
`endif

endmodule
